seq_alu: RTL and testbench
==========================

Name: seq_alu

Overview:
- Parametrised, registered successor to the single-cycle datapath ALU for the pipelined core.
- Adds EOR and an iterative shift-add multiply (MUL, low WIDTH bits of product).
- Uses a valid/ready input handshake and a registered result with NZCV flags.
- Sits in the execute stage; the hazard unit stalls on in_ready low during multi-cycle MUL.

Parameters:
- WIDTH, 32, operand/result width in bits (>=4).
- CNT_W, $clog2(WIDTH)+1, multiply iteration counter width (derived, do not override).

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-low reset (reset==0 clears state on next rising clk edge)
- in_valid  input  1  operands/op presented this cycle
- in_ready  output  1  block can accept an operation this cycle
- a  input  WIDTH  first operand
- b  input  WIDTH  second operand
- ALUControl  input  3  operation select
- out_valid  output  1  one-cycle pulse: Result/Flags updated this cycle
- Result  output  WIDTH  registered result, held until next completion
- Flags  output  4  registered {N,Z,C,V}, held with Result

Behaviour:
- Op codes:
  - 000 ADD; 001 SUB (a + ~b + 1); 010 AND; 011 ORR; 100 EOR.
  - 101 MUL (a*b mod 2^WIDTH).
  - 110/111 reserved: complete in 1 cycle with Result=0 and Flags=0100.
- Flags:
  - N = Result[WIDTH-1]; Z = (Result==0).
  - ADD/SUB: C = carry-out of the WIDTH+1-bit sum; V = operands' signs equal (after conditional invert of b) and sum sign differs from a.
  - Logical ops and MUL: C=0, V=0.
- Accept: in_valid && in_ready at a rising edge captures a, b, ALUControl.
- FSM states: IDLE, MUL.
  - IDLE: in_ready=1.
    - Accepted non-MUL op: Result/Flags written at that edge; out_valid=1 during the following cycle; remains IDLE, so back-to-back ops accept every cycle.
    - Accepted MUL: load multiplicand=a, multiplier=b, acc=0, cnt=0; go to MUL.
  - MUL: in_ready=0; in_valid ignored.
    - Each cycle: if multiplier[0], acc += multiplicand (mod 2^WIDTH); multiplicand <<= 1; multiplier >>= 1; cnt++.
    - When cnt==WIDTH-1, the final iteration writes Result = updated acc and Flags, and the FSM returns to IDLE.
    - out_valid pulses the cycle after that edge.
- Latency from the accept edge to out_valid high: 1 cycle for non-MUL ops, WIDTH cycles for MUL.
- No early termination: MUL always takes exactly WIDTH cycles, even for zero operands.
- out_valid is never high for two consecutive cycles from the same operation. No output backpressure: the consumer must take the result in the out_valid cycle.
- Reset (reset==0 at an edge):
  - State=IDLE, Result=0, Flags=0000, out_valid=0, cnt=0.
  - in_ready reads 1 from the first cycle after reset.
  - Reset mid-MUL aborts without out_valid; the partial product is discarded.
- Reset has priority over acceptance in the same cycle.
- Wrap-around: ADD/SUB are mod 2^WIDTH, with carry and overflow reported through C/V; MUL silently truncates and sets C=V=0.

Decomposition:
- Package alu_pkg:
  - op-code localparams (OP_ADD..OP_MUL, 3 bits).
  - Flag bit indices (FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0).
  - FSM state encoding (ST_IDLE, ST_MUL).
- One sub-module, shift_add_mul:
  - Holds the multiplicand/multiplier/acc/cnt datapath.
  - Ports: start, done pulse, product.
  - The top level owns the FSM, the combinational add/logic path and the flag generation.

Test Plan (WIDTH=32):
- Reset held low 2 cycles, then released -> Result=0, Flags=0000, out_valid=0, in_ready=1.
- SUB a=5, b=5 -> next cycle: out_valid=1, Result=0, Flags=0110 (Z, C set).
- ADD a=0x7FFFFFFF, b=1 -> Result=0x80000000, Flags=1001. ADD a=0xFFFFFFFF, b=1 -> Result=0, Flags=0110.
- Back-to-back: AND 0xF0F0 & 0xFF00, then ORR, then EOR in consecutive cycles -> three consecutive out_valid cycles; Results 0xF000, 0xFFF0, 0x0FF0 in order.
- MUL a=0x10000, b=0x10001 -> in_ready=0 for 32 cycles; out_valid exactly 32 cycles after accept; Result=0x00010000, Flags=0000. Also MUL 0xFFFFFFFF*2 -> Result=0xFFFFFFFE, Flags=1000.
- Reset asserted 10 cycles into a MUL -> no out_valid; Result=0, Flags=0000; in_ready=1 the cycle after reset release; the next ADD 2+3 -> Result=5.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared op codes, flag bit positions and FSM encoding for the sequential ALU.
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_ORR = 3'b011;
    localparam logic [2:0] OP_EOR = 3'b100;
    localparam logic [2:0] OP_MUL = 3'b101;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

endpackage

// File: rtl/shift_add_mul.sv
// Iterative shift-add multiplier datapath; one partial-product step per busy cycle.
module shift_add_mul #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             busy,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [WIDTH-1:0] acc_q;
    logic [CNT_W-1:0] cnt_q;

    // product is the accumulator after this cycle's step, so done can publish it directly
    always_comb begin
        product = acc_q + (mplier_q[0] ? mcand_q : '0);
        done    = busy && (cnt_q == CNT_W'(WIDTH - 1));
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else if (start) begin
            mcand_q  <= a;
            mplier_q <= b;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else if (busy) begin
            acc_q    <= product;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Registered ALU with valid/ready input, NZCV flags and a multi-cycle multiply.
module seq_alu
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       ALUControl,
    output logic             out_valid,
    output logic [WIDTH-1:0] Result,
    output logic [3:0]       Flags
);

    state_t           state_q, state_d;
    logic             accept;
    logic             mul_start, mul_busy, mul_done;
    logic [WIDTH-1:0] mul_product;

    logic             is_sub;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] alu_result;
    logic             alu_c, alu_v;

    logic [WIDTH-1:0] result_q, result_d;
    logic [3:0]       flags_q, flags_d;
    logic             out_valid_q, out_valid_d;

    assign accept = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (accept && ALUControl == OP_MUL) state_d = ST_MUL;
            ST_MUL:  if (mul_done) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == ST_IDLE);
        mul_busy  = (state_q == ST_MUL);
        mul_start = accept && (ALUControl == OP_MUL);
    end

    shift_add_mul #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (mul_start),
        .busy    (mul_busy),
        .a       (a),
        .b       (b),
        .done    (mul_done),
        .product (mul_product)
    );

    // SUB reuses the adder as a + ~b + 1
    always_comb begin
        is_sub = (ALUControl == OP_SUB);
        b_eff  = is_sub ? ~b : b;
        sum    = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
        alu_c  = 1'b0;
        alu_v  = 1'b0;
        case (ALUControl)
            OP_ADD, OP_SUB: begin
                alu_result = sum[WIDTH-1:0];
                alu_c      = sum[WIDTH];
                alu_v      = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  alu_result = a & b;
            OP_ORR:  alu_result = a | b;
            OP_EOR:  alu_result = a ^ b;
            default: alu_result = '0;
        endcase
    end

    always_comb begin
        result_d    = result_q;
        flags_d     = flags_q;
        out_valid_d = 1'b0;
        if (mul_done) begin
            result_d        = mul_product;
            flags_d         = '0;
            flags_d[FLAG_N] = mul_product[WIDTH-1];
            flags_d[FLAG_Z] = (mul_product == '0);
            out_valid_d     = 1'b1;
        end else if (accept && ALUControl != OP_MUL) begin
            result_d        = alu_result;
            flags_d[FLAG_N] = alu_result[WIDTH-1];
            flags_d[FLAG_Z] = (alu_result == '0);
            flags_d[FLAG_C] = alu_c;
            flags_d[FLAG_V] = alu_v;
            out_valid_d     = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            result_q    <= '0;
            flags_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            result_q    <= result_d;
            flags_q     <= flags_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign Result    = result_q;
    assign Flags     = flags_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: directed table, corner sequences, random ops vs. a model.
module tb_seq_alu;
    import alu_pkg::*;

    localparam int unsigned WIDTH = 32;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic [2:0]       ALUControl = '0;
    logic             out_valid;
    logic [WIDTH-1:0] Result;
    logic [3:0]       Flags;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_alu #(
        .WIDTH (WIDTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .ALUControl (ALUControl),
        .out_valid  (out_valid),
        .Result     (Result),
        .Flags      (Flags)
    );

    typedef struct packed {
        logic [2:0]  op;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] res;
        logic [3:0]  flags;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer arithmetic, returns {result, N, Z, C, V}
    function automatic logic [35:0] ref_alu(input logic [2:0] op, input logic [31:0] x,
                                            input logic [31:0] y);
        logic [63:0] ux, uy, p;
        longint      sx, sy, sr;
        logic [31:0] r;
        logic        c, v;
        ux = {32'h0, x};
        uy = {32'h0, y};
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        c  = 1'b0;
        v  = 1'b0;
        r  = '0;
        case (op)
            OP_ADD: begin
                p  = ux + uy;
                r  = p[31:0];
                c  = (p > 64'hFFFF_FFFF);
                sr = sx + sy;
                v  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            end
            OP_SUB: begin
                r  = x - y;
                c  = (ux >= uy);
                sr = sx - sy;
                v  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            end
            OP_AND: r = x & y;
            OP_ORR: r = x | y;
            OP_EOR: r = x ^ y;
            OP_MUL: begin
                p = ux * uy;
                r = p[31:0];
            end
            default: r = '0;
        endcase
        return {r, r[31], (r == 32'h0), c, v};
    endfunction

    // Issues one op, waits for its completion and checks result, flags, latency and pulse width.
    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] exp_r, input logic [3:0] exp_f);
        int n;
        int lows;
        bit done;
        in_valid   = 1'b1;
        ALUControl = op;
        a          = x;
        b          = y;
        tick();
        in_valid = 1'b0;
        if (op == OP_MUL) begin
            n    = 0;
            lows = 0;
            done = 0;
            while (!done && n < 40) begin
                if (!in_ready) lows++;
                tick();
                n++;
                if (out_valid) done = 1;
            end
            check({name, " mul latency"}, n, 32);
            check({name, " in_ready low cycles"}, lows, 32);
        end else begin
            check({name, " out_valid"}, out_valid, 1);
        end
        check({name, " Result"}, Result, exp_r);
        check({name, " Flags"}, Flags, exp_f);
        tick();
        check({name, " single pulse"}, out_valid, 0);
    endtask

    initial begin
        logic [35:0] exp;
        logic [2:0]  op;
        logic [31:0] x, y;
        int          seen;

        vecs[0] = '{OP_SUB, 32'd5, 32'd5, 32'h0, 4'b0110};
        vecs[1] = '{OP_ADD, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 4'b1001};
        vecs[2] = '{OP_ADD, 32'hFFFF_FFFF, 32'd1, 32'h0, 4'b0110};
        vecs[3] = '{OP_SUB, 32'd3, 32'd5, 32'hFFFF_FFFE, 4'b1000};
        vecs[4] = '{OP_SUB, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 4'b0011};
        vecs[5] = '{OP_AND, 32'hF0F0, 32'hFF00, 32'hF000, 4'b0000};
        vecs[6] = '{OP_EOR, 32'hFFFF_FFFF, 32'h0000_FFFF, 32'hFFFF_0000, 4'b1000};
        vecs[7] = '{3'b110, 32'h1234, 32'h5678, 32'h0, 4'b0100};
        vecs[8] = '{OP_MUL, 32'h1_0000, 32'h1_0001, 32'h0001_0000, 4'b0000};
        vecs[9] = '{OP_MUL, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 4'b1000};

        // Reset held for two cycles
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        check("reset Result", Result, 0);
        check("reset Flags", Flags, 0);
        check("reset out_valid", out_valid, 0);
        check("reset in_ready", in_ready, 1);

        for (int i = 0; i < 10; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].x, vecs[i].y, vecs[i].res,
                   vecs[i].flags);
        end

        // Back-to-back logical ops, one accept per cycle
        in_valid   = 1'b1;
        a          = 32'hF0F0;
        b          = 32'hFF00;
        ALUControl = OP_AND;
        tick();
        check("b2b AND out_valid", out_valid, 1);
        check("b2b AND Result", Result, 32'hF000);
        check("b2b AND in_ready", in_ready, 1);
        ALUControl = OP_ORR;
        tick();
        check("b2b ORR out_valid", out_valid, 1);
        check("b2b ORR Result", Result, 32'hFFF0);
        ALUControl = OP_EOR;
        tick();
        check("b2b EOR out_valid", out_valid, 1);
        check("b2b EOR Result", Result, 32'h0FF0);
        in_valid = 1'b0;
        tick();
        check("b2b idle out_valid", out_valid, 0);

        // Reset ten cycles into a MUL aborts it; reset also beats a same-cycle accept
        in_valid   = 1'b1;
        a          = 32'd7;
        b          = 32'd9;
        ALUControl = OP_MUL;
        tick();
        in_valid = 1'b0;
        seen     = 0;
        repeat (10) begin
            tick();
            if (out_valid) seen++;
        end
        check("abort early out_valid", seen, 0);
        reset      = 1'b0;
        in_valid   = 1'b1;
        a          = 32'd7;
        b          = 32'd7;
        ALUControl = OP_ADD;
        tick();
        in_valid = 1'b0;
        check("abort out_valid", out_valid, 0);
        check("abort Result", Result, 0);
        check("abort Flags", Flags, 0);
        reset = 1'b1;
        tick();
        check("abort in_ready", in_ready, 1);
        seen = 0;
        repeat (30) begin
            if (out_valid) seen++;
            tick();
        end
        check("abort no late out_valid", seen, 0);
        check("abort Result held", Result, 0);
        run_op("post-reset ADD", OP_ADD, 32'd2, 32'd3, 32'd5, 4'b0000);

        // Random ops against the model
        for (int i = 0; i < 60; i++) begin
            op = 3'($urandom_range(0, 7));
            x  = ($urandom_range(0, 4) == 0) ? 32'hFFFF_FFFF : $urandom();
            y  = ($urandom_range(0, 4) == 0) ? 32'h8000_0000 : $urandom();
            if ($urandom_range(0, 5) == 0) y = x;
            exp = ref_alu(op, x, y);
            run_op($sformatf("rand%0d op%0d", i, op), op, x, y, exp[35:4], exp[3:0]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
